flash_read_cache: RTL and testbench
===================================

# flash_read_cache

Direct-mapped, read-only cache between the CPU-side instruction/data read path and the QSPI flash controller's AXI4-Lite memory read port. It services reads from flash-mapped addresses. Hits return in two cycles; a miss fills one whole line through single-beat AXI4-Lite reads to the flash controller. Software flushes stale lines after reprogramming flash through an invalidate strobe, which is driven from a register bit.

## Interface
Parameters:
- LINES, 64: number of cache lines; power of two, at least 2.
- WORDS_PER_LINE, 4: 32-bit words per line; power of two, at least 2.
- ADDR_WIDTH, 24: significant flash byte-address bits. Upper address bits are ignored.

Ports:
- CLK  in  1  clock
- RSTb  in  1  reset; synchronous, active-low
- invalidate  in  1  single-cycle strobe that clears all valid bits
- s_axi_arvalid  in  1  upstream read address valid
- s_axi_arready  out  1  upstream read address ready
- s_axi_araddr  in  32  upstream byte address; bits [1:0] ignored
- s_axi_arprot  in  3  ignored
- s_axi_rvalid  out  1  upstream read data valid
- s_axi_rready  in  1  upstream read data ready
- s_axi_rdata  out  32  upstream read data
- m_axi_arvalid  out  1  read address valid to the flash controller
- m_axi_arready  in  1  flash controller address ready
- m_axi_araddr  out  32  word-aligned fill address; bits above ADDR_WIDTH are 0
- m_axi_arprot  out  3  constant 3'b000
- m_axi_rvalid  in  1  fill data valid
- m_axi_rready  out  1  fill data ready
- m_axi_rdata  in  32  fill data

## Operation
- Address split, with IB = log2(LINES) and WB = log2(WORDS_PER_LINE):
  - word = araddr[WB+1:2]
  - index = araddr[IB+WB+1:WB+2]
  - tag = araddr[ADDR_WIDTH-1:IB+WB+2]
- Storage:
  - Data is held in synchronous-read RAM with LINES×WORDS_PER_LINE words.
  - Tags are held in a RAM or register array.
  - Valid bits are flip-flops, so they can be cleared in a single cycle.
- Only one transaction is outstanding at a time on each side.
- State machine:
  - IDLE: s_axi_arready=1. On an s_axi_ar handshake, latch tag, index and word, then go to LOOKUP.
  - LOOKUP: the RAM output is available. On a hit (valid and tag match), go to RESP with s_axi_rdata set to the RAM word. On a miss, clear fill counter k to 0 and go to FILL_AR.
  - FILL_AR: m_axi_arvalid=1 with m_axi_araddr = {tag, index, k, 2'b00}. On an m_axi_ar handshake, go to FILL_R.
  - FILL_R: m_axi_rready=1. On an m_axi_r handshake:
    - write m_axi_rdata to data[index][k];
    - if k equals the requested word, capture the data into the response register;
    - if k = WORDS_PER_LINE-1, write the tag, set valid (unless the line was invalidated during this fill) and go to RESP;
    - otherwise increment k and go to FILL_AR.
  - RESP: s_axi_rvalid=1 with s_axi_rdata stable. On the s_axi_r handshake, go to IDLE.
- Fills always run in order from word 0 to the last word. The counter k never wraps mid-fill.
- The line being filled has its valid bit cleared on entry to FILL_AR, so a partially written line is never reported as a hit.
- invalidate:
  - Clears every valid bit in the same clock edge, in any state.
  - If it arrives during a fill, the fill completes and its data is returned upstream, but the filled line stays invalid.
  - If it arrives in the same cycle as a LOOKUP, the lookup uses the pre-clear valid bits.
- Reset mid-fill: the FSM returns to IDLE and all valid bits clear. Any m_axi_r beat still in flight is dropped because m_axi_rready=0 after reset.

## Timing
- Values during and immediately after reset: s_axi_arready=0, s_axi_rvalid=0, s_axi_rdata=0, m_axi_arvalid=0, m_axi_araddr=0, m_axi_rready=0, all valid bits 0, FSM in IDLE.
- s_axi_arready goes to 1 on the first cycle after RSTb goes high.
- All outputs are registered except m_axi_arprot (constant).
- Hit latency: with the s_axi_ar handshake at edge T, s_axi_rvalid=1 from T+2.
- Miss: m_axi_arvalid=1 from T+2. The next word's m_axi_arvalid rises on the cycle after each m_axi_r handshake.
- Miss response: s_axi_rvalid rises one cycle after the last m_axi_r handshake.
- s_axi_arready is 0 from T+1 and returns to 1 the cycle after the s_axi_r handshake. Back-to-back hits therefore take 3 cycles each.
- Handshake outputs hold under backpressure:
  - s_axi_rvalid and s_axi_rdata hold while s_axi_rready=0.
  - m_axi_arvalid and m_axi_araddr hold while m_axi_arready=0.

## Test plan
- Cold miss: read 0x000010 after reset. Expect m_axi_araddr sequence 0x10, 0x14, 0x18, 0x1C. Return 0xA0..0xA3; expect s_axi_rdata=0xA0.
- Hit: then read 0x000018. Expect s_axi_rvalid 2 cycles after the handshake, data 0xA2, and no m_axi activity.
- Conflict: read 0x000410, which has the same index and a different tag (LINES=64, WPL=4). Expect a refill from 0x410. A re-read of 0x10 then misses again.
- Invalidate: pulse invalidate after the fill of 0x10 completes, then re-read 0x10. Expect a refill. Also pulse invalidate mid-fill: expect data returned upstream and the next read of that line to miss.
- Backpressure:
  - Hold s_axi_rready=0 for 5 cycles: rvalid and rdata stay stable and arready stays 0.
  - Delay m_axi_arready by 3 cycles: the address stays stable.
- Reset during FILL_R: all outputs return to their reset values. A post-reset read of the same address misses and fills correctly.

Source files
------------

// File: rtl/flash_read_cache.sv
// Direct-mapped, read-only cache in front of the QSPI flash controller's AXI4-Lite
// read port. A miss fills the whole line one single-beat read at a time, word 0 first.
module flash_read_cache #(
  parameter int LINES          = 64,
  parameter int WORDS_PER_LINE = 4,
  parameter int ADDR_WIDTH     = 24
) (
  input  logic        CLK,
  input  logic        RSTb,
  input  logic        invalidate,
  input  logic        s_axi_arvalid,
  output logic        s_axi_arready,
  input  logic [31:0] s_axi_araddr,
  input  logic [2:0]  s_axi_arprot,
  output logic        s_axi_rvalid,
  input  logic        s_axi_rready,
  output logic [31:0] s_axi_rdata,
  output logic        m_axi_arvalid,
  input  logic        m_axi_arready,
  output logic [31:0] m_axi_araddr,
  output logic [2:0]  m_axi_arprot,
  input  logic        m_axi_rvalid,
  output logic        m_axi_rready,
  input  logic [31:0] m_axi_rdata
);
  localparam int IB = $clog2(LINES);
  localparam int WB = $clog2(WORDS_PER_LINE);
  localparam int TW = ADDR_WIDTH - IB - WB - 2;

  typedef enum logic [2:0] {IDLE, LOOKUP, FILL_AR, FILL_R, RESP} state_t;

  state_t           r_state;
  logic [31:0]      r_data [LINES*WORDS_PER_LINE];
  logic [TW-1:0]    r_tags [LINES];
  logic [LINES-1:0] r_valid;
  logic [31:0]      r_ramQ;
  logic [TW-1:0]    r_tag;
  logic [IB-1:0]    r_index;
  logic [WB-1:0]    r_word;
  logic [WB-1:0]    r_k;
  logic             r_invFill;
  logic             r_arready;
  logic             r_rvalid;
  logic [31:0]      r_rdata;
  logic             r_marvalid;
  logic [31:0]      r_maraddr;
  logic             r_mrready;

  logic             w_arHs;
  logic             w_fillBeat;
  logic             w_lastBeat;
  logic             w_hit;
  logic [IB+WB-1:0] w_rdAddr;
  logic [IB+WB-1:0] w_wrAddr;
  logic             w_unused;

  assign w_arHs     = s_axi_arvalid && r_arready;
  assign w_fillBeat = (r_state == FILL_R) && m_axi_rvalid;
  assign w_lastBeat = (r_k == WB'(WORDS_PER_LINE - 1));
  assign w_hit      = r_valid[r_index] && (r_tags[r_index] == r_tag);
  assign w_rdAddr   = s_axi_araddr[IB+WB+1:2];
  assign w_wrAddr   = {r_index, r_k};
  assign w_unused   = ^{s_axi_arprot, s_axi_araddr[31:ADDR_WIDTH], s_axi_araddr[1:0]};

  function automatic logic [31:0] fillAddr(input logic [TW-1:0] tag,
                                           input logic [IB-1:0] idx,
                                           input logic [WB-1:0] k);
    logic [31:0] a;
    a = '0;
    a[ADDR_WIDTH-1:0] = {tag, idx, k, 2'b00};
    return a;
  endfunction

  // RAM is read on the handshake edge so its output is ready during LOOKUP
  always_ff @(posedge CLK) begin
    r_ramQ <= r_data[w_rdAddr];
    if (w_fillBeat) begin
      r_data[w_wrAddr] <= m_axi_rdata;
      if (w_lastBeat) r_tags[r_index] <= r_tag;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RSTb) begin
      r_state    <= IDLE;
      r_valid    <= '0;
      r_arready  <= 1'b0;
      r_rvalid   <= 1'b0;
      r_rdata    <= '0;
      r_marvalid <= 1'b0;
      r_maraddr  <= '0;
      r_mrready  <= 1'b0;
      r_tag      <= '0;
      r_index    <= '0;
      r_word     <= '0;
      r_k        <= '0;
      r_invFill  <= 1'b0;
    end else begin
      if (invalidate) r_valid <= '0;
      case (r_state)
        IDLE: begin
          r_arready <= 1'b1;
          if (w_arHs) begin
            r_arready <= 1'b0;
            r_tag     <= s_axi_araddr[ADDR_WIDTH-1:IB+WB+2];
            r_index   <= s_axi_araddr[IB+WB+1:WB+2];
            r_word    <= s_axi_araddr[WB+1:2];
            r_state   <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (w_hit) begin
            r_rdata  <= r_ramQ;
            r_rvalid <= 1'b1;
            r_state  <= RESP;
          end else begin
            // the line is dropped before its first word is overwritten
            r_valid[r_index] <= 1'b0;
            r_k        <= '0;
            r_invFill  <= 1'b0;
            r_marvalid <= 1'b1;
            r_maraddr  <= fillAddr(r_tag, r_index, '0);
            r_state    <= FILL_AR;
          end
        end
        FILL_AR: begin
          if (invalidate) r_invFill <= 1'b1;
          if (m_axi_arready) begin
            r_marvalid <= 1'b0;
            r_mrready  <= 1'b1;
            r_state    <= FILL_R;
          end
        end
        FILL_R: begin
          if (invalidate) r_invFill <= 1'b1;
          if (m_axi_rvalid) begin
            r_mrready <= 1'b0;
            if (r_k == r_word) r_rdata <= m_axi_rdata;
            if (w_lastBeat) begin
              if (!r_invFill && !invalidate) r_valid[r_index] <= 1'b1;
              r_rvalid <= 1'b1;
              r_state  <= RESP;
            end else begin
              r_k        <= r_k + 1'b1;
              r_marvalid <= 1'b1;
              r_maraddr  <= fillAddr(r_tag, r_index, r_k + 1'b1);
              r_state    <= FILL_AR;
            end
          end
        end
        RESP: begin
          if (s_axi_rready) begin
            r_rvalid  <= 1'b0;
            r_arready <= 1'b1;
            r_state   <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign s_axi_arready = r_arready;
  assign s_axi_rvalid  = r_rvalid;
  assign s_axi_rdata   = r_rdata;
  assign m_axi_arvalid = r_marvalid;
  assign m_axi_araddr  = r_maraddr;
  assign m_axi_arprot  = 3'b000;
  assign m_axi_rready  = r_mrready;

endmodule

// File: tb/tb_flash_read_cache.sv
// Directed bench for flash_read_cache: a small flash responder model plus
// read transactions with hand-computed data, fill addresses and latencies.
module tb_flash_read_cache;
  logic        CLK = 1'b0;
  logic        RSTb = 1'b0;
  logic        invalidate = 1'b0;
  logic        sArvalid = 1'b0;
  logic        s_axi_arready;
  logic [31:0] sAraddr = '0;
  logic        s_axi_rvalid;
  logic        sRready = 1'b1;
  logic [31:0] s_axi_rdata;
  logic        m_axi_arvalid;
  logic        mArready = 1'b0;
  logic [31:0] m_axi_araddr;
  logic [2:0]  m_axi_arprot;
  logic        mRvalid = 1'b0;
  logic        m_axi_rready;
  logic [31:0] mRdata = '0;

  int compareCount = 0;
  int mismatchCount = 0;
  int arDelay = 0;
  int arWaitCnt = 0;
  logic arHs = 1'b0;
  logic rHs = 1'b0;
  logic [31:0] arAddrHeld = '0;
  logic [31:0] arFirst = '0;
  logic [31:0] arLog [$];

  flash_read_cache dut (
    .CLK(CLK), .RSTb(RSTb), .invalidate(invalidate),
    .s_axi_arvalid(sArvalid), .s_axi_arready(s_axi_arready), .s_axi_araddr(sAraddr),
    .s_axi_arprot(3'b000), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(sRready),
    .s_axi_rdata(s_axi_rdata), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(mArready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot), .m_axi_rvalid(mRvalid),
    .m_axi_rready(m_axi_rready), .m_axi_rdata(mRdata)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  function automatic logic [31:0] flashWord(input logic [31:0] a);
    if (a[23:4] == 20'h00001) return 32'hA0 + 32'(a[3:2]);
    if (a[23:4] == 20'h00041) return 32'hB0 + 32'(a[3:2]);
    return 32'hF000_0000 | a;
  endfunction

  // Flash responder: acts just after each falling edge, one beat per address
  always begin
    @(negedge CLK);
    #1;
    if (!RSTb) begin
      mArready = 1'b0; mRvalid = 1'b0; arHs = 1'b0; rHs = 1'b0; arWaitCnt = 0;
    end else begin
      if (rHs) mRvalid = 1'b0;
      if (arHs) begin
        arLog.push_back(arAddrHeld);
        mArready = 1'b0;
        mRvalid = 1'b1;
        mRdata = flashWord(arAddrHeld);
      end else if (m_axi_arvalid && !mArready && !mRvalid) begin
        if (arWaitCnt == 0) arFirst = m_axi_araddr;
        else checkOutput("arAddrStable", m_axi_araddr, arFirst);
        if (arWaitCnt >= arDelay) begin
          mArready = 1'b1;
          arWaitCnt = 0;
        end else arWaitCnt++;
      end
      arHs = mArready && m_axi_arvalid;
      arAddrHeld = m_axi_araddr;
      rHs = mRvalid && m_axi_rready;
    end
  end

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_arready"}, 32'(s_axi_arready), 32'd0);
    checkOutput({tag, "_rvalid"}, 32'(s_axi_rvalid), 32'd0);
    checkOutput({tag, "_rdata"}, s_axi_rdata, 32'd0);
    checkOutput({tag, "_marvalid"}, 32'(m_axi_arvalid), 32'd0);
    checkOutput({tag, "_maraddr"}, m_axi_araddr, 32'd0);
    checkOutput({tag, "_mrready"}, 32'(m_axi_rready), 32'd0);
    checkOutput({tag, "_marprot"}, 32'(m_axi_arprot), 32'd0);
  endtask

  // One upstream read; expLatency < 0 skips the latency check
  task automatic applyStimulus(input string tag, input logic [31:0] addr, input logic [31:0] expData,
                               input int expFills, input logic [31:0] fillBase, input int expLatency,
                               input bit invAtLookup, input int rreadyHold);
    int cyc;
    int logBefore;
    cyc = 0;
    while (!s_axi_arready && cyc < 50) begin @(negedge CLK); cyc++; end
    checkOutput({tag, "_arready"}, 32'(s_axi_arready), 32'd1);
    sRready = (rreadyHold == 0);
    sArvalid = 1'b1;
    sAraddr = addr;
    logBefore = arLog.size();
    @(negedge CLK);
    sArvalid = 1'b0;
    cyc = 1;
    checkOutput({tag, "_arreadyLow"}, 32'(s_axi_arready), 32'd0);
    if (invAtLookup) begin
      invalidate = 1'b1;
      @(negedge CLK);
      invalidate = 1'b0;
      cyc = 2;
    end
    while (!s_axi_rvalid && cyc < 300) begin @(negedge CLK); cyc++; end
    checkOutput({tag, "_rvalid"}, 32'(s_axi_rvalid), 32'd1);
    checkOutput({tag, "_rdata"}, s_axi_rdata, expData);
    if (expLatency >= 0) checkOutput({tag, "_latency"}, 32'(cyc), 32'(expLatency));
    checkOutput({tag, "_fills"}, 32'(arLog.size() - logBefore), 32'(expFills));
    for (int i = 0; i < expFills && logBefore + i < arLog.size(); i++)
      checkOutput({tag, "_fillAddr"}, arLog[logBefore+i], fillBase + 32'(4 * i));
    for (int i = 0; i < rreadyHold; i++) begin
      @(negedge CLK);
      checkOutput({tag, "_holdRvalid"}, 32'(s_axi_rvalid), 32'd1);
      checkOutput({tag, "_holdRdata"}, s_axi_rdata, expData);
      checkOutput({tag, "_holdArready"}, 32'(s_axi_arready), 32'd0);
    end
    sRready = 1'b1;
    @(negedge CLK);
    checkOutput({tag, "_rvalidDone"}, 32'(s_axi_rvalid), 32'd0);
    checkOutput({tag, "_arreadyBack"}, 32'(s_axi_arready), 32'd1);
  endtask

  task automatic pulseInvalidateMidFill();
    int cyc;
    cyc = 0;
    while (!m_axi_rready && cyc < 100) begin @(negedge CLK); cyc++; end
    checkOutput("midFillReached", 32'(m_axi_rready), 32'd1);
    invalidate = 1'b1;
    @(negedge CLK);
    invalidate = 1'b0;
  endtask

  initial begin
    int cyc;
    repeat (3) @(negedge CLK);
    checkResetValues("reset");
    RSTb = 1'b1;
    checkOutput("arreadyAtRelease", 32'(s_axi_arready), 32'd0);
    @(negedge CLK);
    checkOutput("arreadyAfterRelease", 32'(s_axi_arready), 32'd1);

    applyStimulus("coldMiss", 32'h10, 32'hA0, 4, 32'h10, 10, 1'b0, 0);
    applyStimulus("hit18", 32'h18, 32'hA2, 0, 32'h0, 2, 1'b0, 0);
    applyStimulus("conflict410", 32'h410, 32'hB0, 4, 32'h410, 10, 1'b0, 0);
    applyStimulus("reMiss10", 32'h10, 32'hA0, 4, 32'h10, 10, 1'b0, 0);
    applyStimulus("hit1C", 32'h1C, 32'hA3, 0, 32'h0, 2, 1'b0, 0);

    invalidate = 1'b1;
    @(negedge CLK);
    invalidate = 1'b0;
    applyStimulus("afterInv", 32'h14, 32'hA1, 4, 32'h10, 10, 1'b0, 0);

    fork
      applyStimulus("midFillInv", 32'h410, 32'hB0, 4, 32'h410, 10, 1'b0, 0);
      pulseInvalidateMidFill();
    join
    applyStimulus("afterMidInv", 32'h414, 32'hB1, 4, 32'h410, 10, 1'b0, 0);
    applyStimulus("invAtLookup", 32'h418, 32'hB2, 0, 32'h0, 2, 1'b1, 0);
    applyStimulus("afterLookupInv", 32'h41C, 32'hB3, 4, 32'h410, 10, 1'b0, 0);
    applyStimulus("rreadyHold", 32'h414, 32'hB1, 0, 32'h0, 2, 1'b0, 5);

    arDelay = 3;
    applyStimulus("arDelay", 32'h30, 32'hF000_0030, 4, 32'h30, -1, 1'b0, 0);
    arDelay = 0;

    cyc = 0;
    while (!s_axi_arready && cyc < 50) begin @(negedge CLK); cyc++; end
    sArvalid = 1'b1;
    sAraddr = 32'h50;
    @(negedge CLK);
    sArvalid = 1'b0;
    cyc = 0;
    while (!m_axi_rready && cyc < 50) begin @(negedge CLK); cyc++; end
    checkOutput("fillRReached", 32'(m_axi_rready), 32'd1);
    RSTb = 1'b0;
    @(negedge CLK);
    checkResetValues("midFillReset");
    @(negedge CLK);
    RSTb = 1'b1;
    @(negedge CLK);
    checkOutput("arreadyAfterReset2", 32'(s_axi_arready), 32'd1);
    applyStimulus("postReset50", 32'h50, 32'hF000_0050, 4, 32'h50, 10, 1'b0, 0);
    applyStimulus("postReset30", 32'h30, 32'hF000_0030, 4, 32'h30, 10, 1'b0, 0);
    applyStimulus("postResetHit", 32'h58, 32'hF000_0058, 0, 32'h0, 2, 1'b0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
